countdown_timer: RTL and testbench

Countdown counterpart to the stopwatch.
- Software or a button loads a start value and toggles run/pause.
- The block decrements once per prescaled tick.
- On reaching zero it raises a one-cycle `expired` pulse, then either stops or reloads automatically.
- It sits beside the stopwatch in the timing subsystem and shares its `toggle` semantics and 4-bit default count width.

---
 rtl/countdown_pkg.sv | 12 +
 rtl/countdown_timer_tick_prescaler.sv | 31 +++
 rtl/countdown_timer.sv | 85 ++++++++
 tb/tb_countdown_timer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides clk into one tick every PRESCALE enabled cycles; phase holds while disabled.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with run/pause toggle, expiry pulse and optional auto-reload.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             toggle,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] timer,
  output logic             running,
  output logic             done,
  output logic             expired
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             tick;
  logic             pre_enable;

  // A load or toggle edge never advances the prescaler, so pausing keeps its phase.
  assign pre_enable = (state == ST_RUNNING) && !load && !toggle;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (pre_enable),
    .clear  (load),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_STOPPED;
      timer   <= '0;
      reload  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        timer  <= load_value;
        reload <= load_value;
        done   <= 1'b0;
        if ((load_value != '0) && (state == ST_RUNNING)) begin
          state   <= ST_RUNNING;
          running <= 1'b1;
        end else begin
          state   <= ST_STOPPED;
          running <= 1'b0;
        end
      end else if (toggle) begin
        if (state == ST_RUNNING) begin
          state   <= ST_STOPPED;
          running <= 1'b0;
        end else if ((state == ST_STOPPED) && (timer != '0)) begin
          state   <= ST_RUNNING;
          running <= 1'b1;
        end
      end else if (tick) begin
        // RUNNING never holds zero, so timer is at least 1 here.
        if (timer > WIDTH'(1)) begin
          timer <= timer - WIDTH'(1);
        end else if (auto_reload && (reload != '0)) begin
          timer   <= reload;
          expired <= 1'b1;
        end else begin
          timer   <= '0;
          expired <= 1'b1;
          state   <= ST_DONE;
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at PRESCALE=1 (dut a) and PRESCALE=4 (dut b).
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [3:0] load_value;
  logic       toggle;
  logic       auto_reload;

  logic [3:0] timer_a, timer_b;
  logic       running_a, running_b, done_a, done_b, expired_a, expired_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .toggle(toggle), .auto_reload(auto_reload),
    .timer(timer_a), .running(running_a), .done(done_a), .expired(expired_a)
  );

  countdown_timer #(.WIDTH(4), .PRESCALE(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .toggle(toggle), .auto_reload(auto_reload),
    .timer(timer_b), .running(running_b), .done(done_b), .expired(expired_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int t, input bit r, input bit d, input bit e);
    chk({tag, ".timer"},   32'(timer_a),   32'(t));
    chk({tag, ".running"}, 32'(running_a), 32'(r));
    chk({tag, ".done"},    32'(done_a),    32'(d));
    chk({tag, ".expired"}, 32'(expired_a), 32'(e));
  endtask

  task automatic chk_b(input string tag, input int t, input bit r, input bit d, input bit e);
    chk({tag, ".timer"},   32'(timer_b),   32'(t));
    chk({tag, ".running"}, 32'(running_b), 32'(r));
    chk({tag, ".done"},    32'(done_b),    32'(d));
    chk({tag, ".expired"}, 32'(expired_b), 32'(e));
  endtask

  initial begin
    reset_n     = 1'b0;
    load        = 1'b0;
    load_value  = 4'd0;
    toggle      = 1'b0;
    auto_reload = 1'b0;
    edge1();
    edge1();
    chk_a("reset_a", 0, 1'b0, 1'b0, 1'b0);
    chk_b("reset_b", 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Basic countdown from 3 at PRESCALE=1
    load = 1'b1; load_value = 4'd3;
    edge1();
    chk_a("load3", 3, 1'b0, 1'b0, 1'b0);
    load = 1'b0; toggle = 1'b1;
    edge1();
    chk_a("start", 3, 1'b1, 1'b0, 1'b0);
    toggle = 1'b0;
    edge1(); chk_a("dec_n1", 2, 1'b1, 1'b0, 1'b0);
    edge1(); chk_a("dec_n2", 1, 1'b1, 1'b0, 1'b0);
    edge1(); chk_a("expire", 0, 1'b0, 1'b1, 1'b1);
    edge1(); chk_a("post_expire", 0, 1'b0, 1'b1, 1'b0);

    // Toggle in DONE has no effect
    toggle = 1'b1;
    edge1(); chk_a("done_toggle", 0, 1'b0, 1'b1, 1'b0);
    toggle = 1'b0;

    // Load 0 then toggle stays stopped
    load = 1'b1; load_value = 4'd0;
    edge1(); chk_a("load0", 0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; toggle = 1'b1;
    edge1(); chk_a("load0_toggle", 0, 1'b0, 1'b0, 1'b0);
    toggle = 1'b0;
    edge1(); chk_a("load0_hold", 0, 1'b0, 1'b0, 1'b0);

    // Load wins over toggle in the same cycle
    load = 1'b1; toggle = 1'b1; load_value = 4'd7;
    edge1(); chk_a("load_toggle", 7, 1'b0, 1'b0, 1'b0);
    load = 1'b0; toggle = 1'b0;
    edge1(); chk_a("load_toggle_hold", 7, 1'b0, 1'b0, 1'b0);

    // PRESCALE=4 pause/resume keeps prescaler phase
    load = 1'b1; load_value = 4'd2;
    edge1(); chk_b("b_load2", 2, 1'b0, 1'b0, 1'b0);
    load = 1'b0; toggle = 1'b1;
    edge1(); chk_b("b_start", 2, 1'b1, 1'b0, 1'b0);
    toggle = 1'b0;
    edge1(); edge1(); edge1();
    chk_b("b_pre_tick", 2, 1'b1, 1'b0, 1'b0);
    edge1(); chk_b("b_tick1", 1, 1'b1, 1'b0, 1'b0);
    edge1(); edge1();
    toggle = 1'b1;
    edge1(); chk_b("b_pause", 1, 1'b0, 1'b0, 1'b0);
    toggle = 1'b0;
    repeat (10) edge1();
    chk_b("b_paused", 1, 1'b0, 1'b0, 1'b0);
    toggle = 1'b1;
    edge1(); chk_b("b_resume", 1, 1'b1, 1'b0, 1'b0);
    toggle = 1'b0;
    edge1(); chk_b("b_resume1", 1, 1'b1, 1'b0, 1'b0);
    edge1(); chk_b("b_expire", 0, 1'b0, 1'b1, 1'b1);

    // Auto-reload at PRESCALE=1 with reload value 2
    auto_reload = 1'b1;
    load = 1'b1; load_value = 4'd2;
    edge1(); chk_a("ar_load", 2, 1'b0, 1'b0, 1'b0);
    load = 1'b0; toggle = 1'b1;
    edge1(); chk_a("ar_start", 2, 1'b1, 1'b0, 1'b0);
    toggle = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      edge1();
      chk_a($sformatf("ar_cyc%0d", i), (i % 2 == 1) ? 1 : 2, 1'b1, 1'b0, (i % 2 == 0));
    end

    // Asynchronous reset while running with timer=5
    load = 1'b1; load_value = 4'd5;
    edge1(); chk_a("run_load5", 5, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 1'b0, 1'b0, 1'b0);
    edge1();
    reset_n = 1'b1;
    edge1(); edge1();
    chk_a("post_rst", 0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
